alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, multi-cycle successor to the single-cycle execute ALU in the miniRV pipeline. It sits in the EX stage and adds the RV32M multiply, divide and remainder operations using iterative, one-bit-per-cycle engines. It also registers every result behind a valid/ready/done handshake, so the pipeline can stall on long operations. The datapath width is a parameter; the operand-B source select (register or sign-extended immediate) and the branch flag are retained.

## Interface
- XLEN, 32, datapath width; power of two, 8 to 64
- SHW, $clog2(XLEN), shift-amount width (derived; do not override)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  request; takes effect only when ready_o=1
- kill_i  in  1  synchronous abort (pipeline flush); has priority over valid_i
- op_i  in  5  operation code; see Operation
- A_i  in  XLEN  operand A
- B_i  in  XLEN  register operand B
- imm_i  in  XLEN  SEXT immediate
- alub_sel_i  in  1  1: B=imm_i, 0: B=B_i
- ready_o  out  1  block can accept a request this cycle
- done_o  out  1  one-cycle pulse; C_o and br_f_o are valid
- C_o  out  XLEN  registered result
- br_f_o  out  1  registered branch-taken flag

## Operation

**Operand capture**
- A request is accepted on a rising edge with valid_i & ready_o & ~kill_i.
- A and the muxed B are captured at accept; later changes to the inputs are ignored.

**Opcodes**
- Simple ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- Shifts use B[SHW-1:0]. SLT/SLTU write 0 or 1 to C_o.
- Branch ops: 17 BEQ, 18 BNE, 19 BLT, 20 BGE, 21 BLTU, 22 BGEU.
  - BLT/BGE are signed; BLTU/BGEU are unsigned.
  - C_o = A−B for branch ops.
- Iterative ops: 10 MUL (low word), 11 MULH (signed×signed, high word), 12 MULHU (unsigned high word), 13 DIV, 14 DIVU, 15 REM, 16 REMU.
- br_f_o = 0 for every non-branch op.
- Undefined op (23–31): C_o = 0, br_f_o = 0, completes as a simple op.

**Iterative arithmetic**
- Signed ops are computed on magnitudes; the result sign is fixed in the final cycle.
  - Product sign = sign(A) xor sign(B).
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
- Multiply: shift-add into a 2·XLEN accumulator, one multiplier bit per cycle, XLEN iterations.
- Divide: restoring division, one quotient bit per cycle, XLEN iterations.

**Special cases (resolved at accept, take the simple-op latency)**
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = A.
- Signed overflow (A = most-negative, B = −1): DIV = A; REM = 0.

**State machine: IDLE, CALC, FIN**
- IDLE:
  - accept of a simple op, undefined op or special case → FIN, result registered.
  - accept of an iterative op → CALC, iteration counter loaded with XLEN−1.
- CALC:
  - one iteration per cycle; counter decrements.
  - at counter = 0 → FIN, sign-fixed result registered.
- FIN:
  - done_o = 1 for this one cycle.
  - a new accept this cycle follows the IDLE rules; otherwise → IDLE.
- kill_i in any state → IDLE next edge. No done_o is produced for the killed operation. C_o and br_f_o keep their last completed values.

**Outputs**
- ready_o = (state != CALC).
- C_o and br_f_o hold the last completed result until the next done_o.

**Reset (asynchronous, rst_i=1)**
- state = IDLE, counter = 0.
- C_o = 0, br_f_o = 0, done_o = 0, ready_o = 1.
- Reset mid-CALC discards the operation; no done_o is produced.

## Timing
- Accept on edge k:
  - simple op, undefined op or special case: done_o high in cycle k+1 (latency 1).
  - iterative op: done_o high in cycle k+XLEN+1 (latency XLEN+1; 33 for XLEN=32).
- Throughput:
  - simple ops: one per cycle, back-to-back through FIN.
  - iterative ops: one per XLEN+1 cycles.
- valid_i while ready_o=0 is ignored; the requester holds valid_i until it sees ready_o=1.
- kill_i and valid_i high on the same edge: kill wins; the request is not accepted.
- All outputs are registered; there is no combinational input→output path except through ready_o (state only).

## Test plan
- Reset and simple ops: assert rst_i mid-cycle → all outputs take reset values immediately. Then ADD A=7, imm_i=−3 with alub_sel_i=1 → done_o in cycle k+1, C_o = 4.
- Branch op: BLT A=0xFFFFFFFF, B=1 → br_f_o = 1. BLTU with the same operands → br_f_o = 0. Issue back-to-back on consecutive edges → one done_o per cycle.
- Multiply: MUL 0xFFFFFFFF×2 → C_o = 0xFFFFFFFE. MULH −2×3 → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. Each: done_o exactly 33 cycles after accept; ready_o = 0 for 32 cycles.
- Divide: DIV −7/2 → −3; REM −7/2 → −1; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases: DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM 0x80000000/−1 → 0. Each with 1-cycle latency.
- Abort paths: kill_i at CALC cycle 10 → no done_o, ready_o = 1 next cycle, C_o unchanged, a following ADD completes normally. rst_i mid-CALC → same abort behaviour. valid_i during CALC → ignored.

Source files
------------

// File: rtl/alu_iter.sv
// Multi-cycle EX-stage ALU: single-cycle integer/branch ops plus iterative
// shift-add multiply and restoring divide, with a registered valid/ready/done result.
module alu_iter #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            kill_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] B_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            alub_sel_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] C_o,
  output logic            br_f_o
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_MUL   = 5'd10;
  localparam logic [4:0] OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHU = 5'd12;
  localparam logic [4:0] OP_DIV   = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;
  localparam logic [4:0] OP_REM   = 5'd15;
  localparam logic [4:0] OP_REMU  = 5'd16;
  localparam logic [4:0] OP_BEQ   = 5'd17;
  localparam logic [4:0] OP_BNE   = 5'd18;
  localparam logic [4:0] OP_BLT   = 5'd19;
  localparam logic [4:0] OP_BGE   = 5'd20;
  localparam logic [4:0] OP_BLTU  = 5'd21;
  localparam logic [4:0] OP_BGEU  = 5'd22;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIN} state_t;

  state_t state, state_nxt;

  logic [SHW-1:0]    cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [4:0]        op_q;
  logic              neg_q, neg_r;

  logic [XLEN-1:0] b_mux;
  logic [SHW-1:0]  shamt;
  logic            accept, is_iter, is_div, b_zero, ovf, special, go_calc;
  logic            sgn_op, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] simple_c;
  logic            simple_br;

  assign ready_o = (state != ST_CALC);
  assign b_mux   = alub_sel_i ? imm_i : B_i;
  assign shamt   = b_mux[SHW-1:0];
  assign accept  = valid_i & ready_o & ~kill_i;

  assign is_iter = (op_i >= OP_MUL) && (op_i <= OP_REMU);
  assign is_div  = (op_i >= OP_DIV) && (op_i <= OP_REMU);
  assign b_zero  = (b_mux == '0);
  assign ovf     = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                   (A_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_mux);
  assign special = (is_div & b_zero) | ovf;
  assign go_calc = is_iter & ~special;

  // Engines work on magnitudes; the sign is restored on the last iteration.
  assign sgn_op = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_neg  = sgn_op & A_i[XLEN-1];
  assign b_neg  = sgn_op & b_mux[XLEN-1];
  assign mag_a  = a_neg ? -A_i : A_i;
  assign mag_b  = b_neg ? -b_mux : b_mux;

  always_comb begin
    simple_c  = '0;
    simple_br = 1'b0;
    case (op_i)
      OP_ADD:  simple_c = A_i + b_mux;
      OP_SUB:  simple_c = A_i - b_mux;
      OP_AND:  simple_c = A_i & b_mux;
      OP_OR:   simple_c = A_i | b_mux;
      OP_XOR:  simple_c = A_i ^ b_mux;
      OP_SLL:  simple_c = A_i << shamt;
      OP_SRL:  simple_c = A_i >> shamt;
      OP_SRA:  simple_c = $signed(A_i) >>> shamt;
      OP_SLT:  simple_c = XLEN'($signed(A_i) < $signed(b_mux));
      OP_SLTU: simple_c = XLEN'(A_i < b_mux);
      OP_DIV, OP_DIVU: simple_c = b_zero ? '1 : A_i;
      OP_REM, OP_REMU: simple_c = b_zero ? A_i : '0;
      OP_BEQ:  begin simple_c = A_i - b_mux; simple_br = (A_i == b_mux); end
      OP_BNE:  begin simple_c = A_i - b_mux; simple_br = (A_i != b_mux); end
      OP_BLT:  begin simple_c = A_i - b_mux; simple_br = ($signed(A_i) < $signed(b_mux)); end
      OP_BGE:  begin simple_c = A_i - b_mux; simple_br = ($signed(A_i) >= $signed(b_mux)); end
      OP_BLTU: begin simple_c = A_i - b_mux; simple_br = (A_i < b_mux); end
      OP_BGEU: begin simple_c = A_i - b_mux; simple_br = (A_i >= b_mux); end
      default: ;
    endcase
  end

  // Shared accumulator: multiply keeps {partial product, multiplier};
  // divide keeps {partial remainder, dividend/quotient}.
  logic            is_mul_q;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   r_sh;
  logic [XLEN:0]   r_diff;
  logic            r_ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, prod_neg;
  logic [XLEN-1:0] quo, rem, fin_c;

  assign is_mul_q = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt  = {mul_sum, acc[XLEN-1:1]};
  assign r_sh     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign r_diff   = r_sh - {1'b0, opnd};
  assign r_ge     = (r_sh >= {1'b0, opnd});
  assign div_nxt  = {(r_ge ? r_diff[XLEN-1:0] : r_sh[XLEN-1:0]), acc[XLEN-2:0], r_ge};
  assign acc_nxt  = is_mul_q ? mul_nxt : div_nxt;
  assign prod_neg = -acc_nxt;
  assign quo      = acc_nxt[XLEN-1:0];
  assign rem      = acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    fin_c = '0;
    case (op_q)
      OP_MUL:   fin_c = acc_nxt[XLEN-1:0];
      OP_MULH:  fin_c = neg_q ? prod_neg[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
      OP_MULHU: fin_c = acc_nxt[2*XLEN-1:XLEN];
      OP_DIV:   fin_c = neg_q ? -quo : quo;
      OP_DIVU:  fin_c = quo;
      OP_REM:   fin_c = neg_r ? -rem : rem;
      OP_REMU:  fin_c = rem;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_FIN: begin
        if (accept) state_nxt = go_calc ? ST_CALC : ST_FIN;
        else        state_nxt = ST_IDLE;
      end
      ST_CALC: if (cnt == '0) state_nxt = ST_FIN;
      default: state_nxt = ST_IDLE;
    endcase
    if (kill_i) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      C_o    <= '0;
      br_f_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (kill_i) begin
        cnt <= '0;
      end else if (accept) begin
        if (go_calc) begin
          acc   <= {{XLEN{1'b0}}, mag_a};
          opnd  <= mag_b;
          op_q  <= op_i;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= SHW'(XLEN-1);
        end else begin
          C_o    <= simple_c;
          br_f_o <= simple_br;
          done_o <= 1'b1;
        end
      end else if (state == ST_CALC) begin
        acc <= acc_nxt;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          C_o    <= fin_c;
          br_f_o <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Randomized self-checking bench for alu_iter against a plain-arithmetic reference model.
module tb_alu_iter;
  localparam int XLEN = 32;

  logic        clk = 1'b0, rst = 1'b0, valid = 1'b0, kill = 1'b0, sel = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] a = '0, b = '0, imm = '0;
  logic        ready, done, br;
  logic [31:0] c;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .kill_i(kill), .op_i(op),
    .A_i(a), .B_i(b), .imm_i(imm), .alub_sel_i(sel),
    .ready_o(ready), .done_o(done), .C_o(c), .br_f_o(br)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    return ((o >= 13 && o <= 16) && y == 0) ||
           ((o == 13 || o == 15) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic f);
    int sx, sy;
    longint sp;
    logic [63:0] up;
    sx = x; sy = y;
    sp = longint'(sx) * longint'(sy);
    up = {32'b0, x} * {32'b0, y};
    f = 1'b0;
    r = '0;
    case (o)
      0: r = x + y;
      1: r = x - y;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = x << y[4:0];
      6: r = x >> y[4:0];
      7: r = 32'(sx >>> y[4:0]);
      8: r = {31'b0, sx < sy};
      9: r = {31'b0, x < y};
      10: r = up[31:0];
      11: r = 32'(sp >>> 32);
      12: r = up[63:32];
      13: r = (y == 0) ? 32'hFFFF_FFFF : is_special(o, x, y) ? x : 32'(sx / sy);
      14: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      15: r = (y == 0) ? x : is_special(o, x, y) ? 32'h0 : 32'(sx % sy);
      16: r = (y == 0) ? x : x % y;
      17: begin r = x - y; f = (x == y); end
      18: begin r = x - y; f = (x != y); end
      19: begin r = x - y; f = (sx < sy); end
      20: begin r = x - y; f = (sx >= sy); end
      21: begin r = x - y; f = (x < y); end
      22: begin r = x - y; f = (x >= y); end
      default: ;
    endcase
  endfunction

  // selm: 0/1 force operand-B source, 2 picks it at random
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int selm, input bit noise);
    logic [31:0] er;
    logic ef;
    int exp_lat, lat, rdy_lo;
    model(o, x, y, er, ef);
    exp_lat = (o >= 10 && o <= 16 && !is_special(o, x, y)) ? XLEN + 1 : 1;
    @(negedge clk);
    op = o; a = x;
    sel = (selm == 2) ? 1'($urandom_range(0, 1)) : 1'(selm);
    if (sel) begin imm = y; b = $urandom; end
    else     begin b = y; imm = $urandom; end
    valid = 1'b1;
    @(posedge clk); #1;
    valid = noise;
    op = 5'd0; a = $urandom; b = $urandom; imm = $urandom;
    lat = 1; rdy_lo = 0;
    while (!done && lat < 100) begin
      if (!ready) rdy_lo++;
      @(posedge clk); #1;
      lat++;
    end
    valid = 1'b0;
    chk($sformatf("lat op%0d", o), 64'(lat), 64'(exp_lat));
    chk($sformatf("C op%0d %h,%h", o, x, y), 64'(c), 64'(er));
    chk($sformatf("br op%0d", o), 64'(br), 64'(ef));
    chk($sformatf("busy op%0d", o), 64'(rdy_lo), 64'(exp_lat - 1));
    @(posedge clk); #1;
    chk("done pulse", 64'(done), 64'd0);
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin @(posedge clk); #1; if (done) cnt++; end
  endtask

  initial begin
    int nd;
    logic [4:0] ro;
    logic [31:0] rx, ry;

    #2 rst = 1'b1;
    #1;
    chk("rst ready", 64'(ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst C", 64'(c), 64'd0);
    chk("rst br", 64'(br), 64'd0);
    @(negedge clk) rst = 1'b0;

    run_op(5'd0, 32'd7, 32'hFFFF_FFFD, 1, 1'b0);
    run_op(5'd19, 32'hFFFF_FFFF, 32'd1, 2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async rst C", 64'(c), 64'd0);
    chk("async rst br", 64'(br), 64'd0);
    chk("async rst ready", 64'(ready), 64'd1);
    @(negedge clk) rst = 1'b0;

    // back-to-back branches: one done per cycle
    @(negedge clk);
    op = 5'd19; a = 32'hFFFF_FFFF; b = 32'd1; sel = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b done0", 64'(done), 64'd1);
    chk("b2b blt", 64'(br), 64'd1);
    op = 5'd21;
    @(posedge clk); #1;
    chk("b2b done1", 64'(done), 64'd1);
    chk("b2b bltu", 64'(br), 64'd0);
    chk("b2b C", 64'(c), 64'hFFFF_FFFE);
    valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b idle", 64'(done), 64'd0);

    run_op(5'd10, 32'hFFFF_FFFF, 32'd2, 2, 1'b0);
    run_op(5'd11, 32'hFFFF_FFFE, 32'd3, 2, 1'b0);
    run_op(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b1);
    run_op(5'd13, 32'hFFFF_FFF9, 32'd2, 2, 1'b0);
    run_op(5'd15, 32'hFFFF_FFF9, 32'd2, 2, 1'b0);
    run_op(5'd14, 32'd100, 32'd7, 2, 1'b1);
    run_op(5'd16, 32'd100, 32'd7, 2, 1'b0);
    run_op(5'd13, 32'd5, 32'd0, 2, 1'b0);
    run_op(5'd15, 32'd5, 32'd0, 2, 1'b0);
    run_op(5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0);
    run_op(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0);
    run_op(5'd25, 32'd9, 32'd9, 2, 1'b0);

    // kill at CALC cycle 10, colliding with a new request
    run_op(5'd0, 32'd5, 32'd6, 0, 1'b0);
    @(negedge clk);
    op = 5'd14; a = 32'd100; b = 32'd7; sel = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1; valid = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    kill = 1'b0; valid = 1'b0;
    chk("kill ready", 64'(ready), 64'd1);
    chk("kill done", 64'(done), 64'd0);
    chk("kill C", 64'(c), 64'd11);
    count_done(40, nd);
    chk("kill no done", 64'(nd), 64'd0);
    run_op(5'd0, 32'd20, 32'd22, 2, 1'b0);

    // reset in the middle of a multiply
    @(negedge clk);
    op = 5'd10; a = 32'd1234; b = 32'd77; sel = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("calc rst ready", 64'(ready), 64'd1);
    chk("calc rst done", 64'(done), 64'd0);
    chk("calc rst C", 64'(c), 64'd0);
    @(negedge clk) rst = 1'b0;
    count_done(40, nd);
    chk("calc rst no done", 64'(nd), 64'd0);
    run_op(5'd1, 32'd3, 32'd10, 2, 1'b0);

    for (int i = 0; i < 80; i++) begin
      ro = 5'($urandom_range(0, 31));
      rx = $urandom; ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: begin rx = $urandom_range(0, 300); ry = $urandom_range(1, 20); end
        3: ry = rx;
        default: ;
      endcase
      run_op(ro, rx, ry, 2, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
